// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU.
//   alu_op_e    : 4-bit operation codes (14 and 15 are unused and produce zero)
//   alu_state_e : control FSM states
//   is_iter()   : true for the multi-cycle multiply/divide ops
package alu_pkg;

  typedef enum logic [3:0] {
    OpAnd   = 4'd0,
    OpOr    = 4'd1,
    OpAdd   = 4'd2,
    OpSub   = 4'd3,
    OpXor   = 4'd4,
    OpSlt   = 4'd5,
    OpSltu  = 4'd6,
    OpSll   = 4'd7,
    OpSrl   = 4'd8,
    OpSra   = 4'd9,
    OpMul   = 4'd10,
    OpMulhu = 4'd11,
    OpDivu  = 4'd12,
    OpRemu  = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StHold
  } alu_state_e;

  function automatic logic is_iter(logic [3:0] op);
    return (op >= 4'(OpMul)) && (op <= 4'(OpRemu));
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bus of the sequential ALU.
//   in_valid/in_ready   : operand handshake (op, a, b)
//   out_valid/out_ready : result handshake (result, zero, ltez)
//   busy                : multi-cycle op in progress
// master = producer/consumer side, slave = ALU side.
interface alu_seq_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            ltez;
  logic            busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, ltez, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, ltez, busy
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply / divide unit, one step per cycle for XLEN cycles.
//   clk, rst_n : clock, async active-low reset
//   start_i    : load operands and begin (op_i, a_i, b_i sampled here)
//   done_o     : high during the last iteration cycle
//   result_o   : final result, valid while done_o is high
// A single 2*XLEN register is shared: {hi, lo} product for MUL/MULHU and
// {remainder, quotient} for DIVU/REMU.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  localparam int unsigned SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  alu_op_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [SHW-1:0] LastCnt = SHW'(XLEN - 1);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic              active_q, active_d;
  alu_op_e           op_q, op_d;

  logic              is_div;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     diff;
  logic [XLEN:0]     sum;

  assign is_div = (op_q == OpDivu) || (op_q == OpRemu);

  always_comb begin
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    op_d      = op_q;
    rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff      = rem_shift - {1'b0, opnd_q};
    sum       = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    if (start_i) begin
      acc_d    = {{XLEN{1'b0}}, a_i};
      opnd_d   = b_i;
      op_d     = op_i;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (is_div) begin
        // Restoring step; a borrow (diff[XLEN]) means keep the shifted remainder.
        // With a zero divisor this never borrows: quotient all ones, remainder = a.
        if (!diff[XLEN]) begin
          acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
      end else begin
        // Shift-add: conditionally add multiplicand to the high half, then shift right.
        acc_d = {sum, acc_q[XLEN-1:1]};
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LastCnt) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      op_q     <= OpMul;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      op_q     <= op_d;
    end
  end

  // Result is taken from the next-state value so the caller can latch it on the last step.
  assign done_o   = active_q && (cnt_q == LastCnt);
  assign result_o = ((op_q == OpMulhu) || (op_q == OpRemu)) ? acc_d[2*XLEN-1:XLEN]
                                                            : acc_d[XLEN-1:0];

endmodule

// File: rtl/alu_seq.sv
// Sequential integer ALU for the execute stage.
//   clk, rst_n : clock, async active-low reset
//   bus        : alu_seq_if slave (operand handshake, held result slot, flags, busy)
// Single-cycle ops are registered at the accept edge; MUL/MULHU/DIVU/REMU run in
// alu_muldiv_iter. The result is held until the consumer asserts out_ready.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  localparam int unsigned SHW = $clog2(XLEN)
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;
  alu_op_e         op_e;
  logic            md_start;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  assign op_e  = alu_op_e'(bus.op);
  assign shamt = bus.b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (op_e)
      OpAnd:   alu_res = bus.a & bus.b;
      OpOr:    alu_res = bus.a | bus.b;
      OpAdd:   alu_res = bus.a + bus.b;
      OpSub:   alu_res = bus.a - bus.b;
      OpXor:   alu_res = bus.a ^ bus.b;
      OpSlt:   alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OpSltu:  alu_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
      OpSll:   alu_res = bus.a << shamt;
      OpSrl:   alu_res = bus.a >> shamt;
      OpSra:   alu_res = $unsigned($signed(bus.a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  assign md_start = (state_q == StIdle) && bus.in_valid && is_iter(bus.op);

  alu_muldiv_iter #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (md_start),
    .op_i     (op_e),
    .a_i      (bus.a),
    .b_i      (bus.b),
    .done_o   (md_done),
    .result_o (md_result)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (is_iter(bus.op)) begin
            state_d = StCalc;
          end else begin
            result_d = alu_res;
            state_d  = StHold;
          end
        end
      end
      StCalc: begin
        if (md_done) begin
          result_d = md_result;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q == StCalc);
  assign bus.out_valid = (state_q == StHold);
  assign bus.result    = result_q;
  assign bus.zero      = (result_q == '0);
  assign bus.ltez      = (result_q == '0) || result_q[XLEN-1];

endmodule
